// File: rtl/phys_regfile.sv
// Multi-ported physical register file: data plus ready bit per entry, entry 0 hardwired to zero/ready.
// Optional same-cycle write-to-read forwarding is enabled by defining PHYS_REGFILE_BYPASS_EN.
module phys_regfile #(
  parameter int N_ENTRIES     = 64,
  parameter int ENTRY_WIDTH   = 32,
  parameter int N_READ_PORTS  = 4,
  parameter int N_WRITE_PORTS = 2,
  parameter int N_CLR_PORTS   = 2,
  localparam int PTR_WIDTH    = $clog2(N_ENTRIES)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [N_READ_PORTS-1:0][PTR_WIDTH-1:0]    rd_addr,
  output logic [N_READ_PORTS-1:0][ENTRY_WIDTH-1:0]  rd_data,
  output logic [N_READ_PORTS-1:0]                   rd_ready,
  input  logic [N_WRITE_PORTS-1:0]                  wr_en,
  input  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]   wr_addr,
  input  logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] wr_data,
  input  logic [N_CLR_PORTS-1:0]                    clr_en,
  input  logic [N_CLR_PORTS-1:0][PTR_WIDTH-1:0]     clr_addr,
  input  logic                                      init,
  input  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]     init_entry_reg_state,
  input  logic [N_ENTRIES-1:0]                      init_ready_state,
  output logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]     current_entry_reg_state,
  output logic [N_ENTRIES-1:0]                      current_ready_state
);

  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] data_q, data_d;
  logic [N_ENTRIES-1:0]                  ready_q, ready_d;

  // Writes in ascending port order so the highest port wins; clears applied last so they win over writes.
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    if (init) begin
      data_d  = init_entry_reg_state;
      ready_d = init_ready_state;
    end else begin
      for (int p = 0; p < N_WRITE_PORTS; p++) begin
        if (wr_en[p]) begin
          data_d[wr_addr[p]]  = wr_data[p];
          ready_d[wr_addr[p]] = 1'b1;
        end
      end
      for (int c = 0; c < N_CLR_PORTS; c++) begin
        if (clr_en[c]) begin
          ready_d[clr_addr[c]] = 1'b0;
        end
      end
    end
    data_d[0]  = '0;
    ready_d[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      ready_q <= '1;
    end else begin
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

`ifdef PHYS_REGFILE_BYPASS_EN
  logic [N_READ_PORTS-1:0] byp_hit;
`endif

  always_comb begin
`ifdef PHYS_REGFILE_BYPASS_EN
    byp_hit = '0;
`endif
    for (int r = 0; r < N_READ_PORTS; r++) begin
      rd_data[r]  = data_q[rd_addr[r]];
      rd_ready[r] = ready_q[rd_addr[r]];
`ifdef PHYS_REGFILE_BYPASS_EN
      if (!init) begin
        for (int p = 0; p < N_WRITE_PORTS; p++) begin
          if (wr_en[p] && (wr_addr[p] == rd_addr[r])) begin
            byp_hit[r]  = 1'b1;
            rd_data[r]  = wr_data[p];
            rd_ready[r] = 1'b1;
          end
        end
        for (int c = 0; c < N_CLR_PORTS; c++) begin
          if (byp_hit[r] && clr_en[c] && (clr_addr[c] == rd_addr[r])) begin
            rd_ready[r] = 1'b0;
          end
        end
      end
`endif
      if (rst || (rd_addr[r] == '0)) begin
        rd_data[r]  = '0;
        rd_ready[r] = 1'b1;
      end
    end
  end

  assign current_entry_reg_state = data_q;
  assign current_ready_state     = ready_q;

endmodule

// File: tb/tb_phys_regfile.sv
// Self-checking bench for phys_regfile: directed scenarios followed by randomized traffic against an array model.
module tb_phys_regfile;
  localparam int NE = 64;
  localparam int EW = 32;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int NC = 2;
  localparam int PW = 6;

  logic                   clk = 1'b0;
  logic                   rst, init;
  logic [NR-1:0][PW-1:0]  rd_addr;
  logic [NR-1:0][EW-1:0]  rd_data;
  logic [NR-1:0]          rd_ready;
  logic [NW-1:0]          wr_en;
  logic [NW-1:0][PW-1:0]  wr_addr;
  logic [NW-1:0][EW-1:0]  wr_data;
  logic [NC-1:0]          clr_en;
  logic [NC-1:0][PW-1:0]  clr_addr;
  logic [NE-1:0][EW-1:0]  init_entry_reg_state;
  logic [NE-1:0]          init_ready_state;
  logic [NE-1:0][EW-1:0]  current_entry_reg_state;
  logic [NE-1:0]          current_ready_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [EW-1:0] m_data [NE];
  logic          m_rdy  [NE];

  phys_regfile dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_en(clr_en), .clr_addr(clr_addr),
    .init(init), .init_entry_reg_state(init_entry_reg_state), .init_ready_state(init_ready_state),
    .current_entry_reg_state(current_entry_reg_state), .current_ready_state(current_ready_state)
  );

  always #5 clk = ~clk;

  // Model update from the inputs present at the rising edge.
  function automatic void commit();
    if (rst) begin
      for (int e = 0; e < NE; e++) begin m_data[e] = '0; m_rdy[e] = 1'b1; end
    end else if (init) begin
      for (int e = 0; e < NE; e++) begin m_data[e] = init_entry_reg_state[e]; m_rdy[e] = init_ready_state[e]; end
    end else begin
      for (int p = 0; p < NW; p++)
        if (wr_en[p] && wr_addr[p] != 0) begin m_data[wr_addr[p]] = wr_data[p]; m_rdy[wr_addr[p]] = 1'b1; end
      for (int c = 0; c < NC; c++)
        if (clr_en[c] && clr_addr[c] != 0) m_rdy[clr_addr[c]] = 1'b0;
    end
    m_data[0] = '0;
    m_rdy[0]  = 1'b1;
  endfunction

  task automatic exp_rd(input int a, output logic [EW-1:0] d, output logic r);
    d = m_data[a];
    r = m_rdy[a];
`ifdef PHYS_REGFILE_BYPASS_EN
    if (!init) begin
      bit hit = 0;
      for (int p = 0; p < NW; p++)
        if (wr_en[p] && int'(wr_addr[p]) == a) begin hit = 1; d = wr_data[p]; r = 1'b1; end
      for (int c = 0; c < NC; c++)
        if (hit && clr_en[c] && int'(clr_addr[c]) == a) r = 1'b0;
    end
`endif
    if (rst || a == 0) begin d = '0; r = 1'b1; end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_reads();
    logic [EW-1:0] d;
    logic          r;
    for (int i = 0; i < NR; i++) begin
      exp_rd(int'(rd_addr[i]), d, r);
      chk($sformatf("rd_data[%0d] addr %0d", i, rd_addr[i]), 64'(rd_data[i]), 64'(d));
      chk($sformatf("rd_ready[%0d] addr %0d", i, rd_addr[i]), 64'(rd_ready[i]), 64'(r));
    end
  endtask

  task automatic check_state();
    int bad = -1;
    int e0;
    for (int e = 0; e < NE; e++)
      if (bad < 0 && (current_entry_reg_state[e] !== m_data[e] || current_ready_state[e] !== m_rdy[e])) bad = e;
    e0 = (bad < 0) ? 0 : bad;
    total_cnt++;
    assert (bad == -1) pass_cnt++;
    else $error("FAIL cur_state entry %0d: got %h/%b expected %h/%b", e0,
                current_entry_reg_state[e0], current_ready_state[e0], m_data[e0], m_rdy[e0]);
  endtask

  task automatic tick();
    @(posedge clk);
    commit();
    #1;
    rst = 0; init = 0; wr_en = '0; clr_en = '0;
    #1;
  endtask

  initial begin
    rst = 0; init = 0; wr_en = '0; clr_en = '0; rd_addr = '0;
    wr_addr = '0; wr_data = '0; clr_addr = '0;
    init_entry_reg_state = '0; init_ready_state = '0;
    for (int e = 0; e < NE; e++) begin m_data[e] = '0; m_rdy[e] = 1'b1; end

    // Reset with reads on 0,1,5,63
    rst = 1;
    rd_addr[0] = 6'd0; rd_addr[1] = 6'd1; rd_addr[2] = 6'd5; rd_addr[3] = 6'd63;
    #1 check_reads();
    tick();
    check_reads();
    chk("reset ready all ones", 64'(current_ready_state), {64{1'b1}});
    check_state();

    // Write then read
    wr_en = 2'b01; wr_addr[0] = 6'd5; wr_data[0] = 32'h12345678; rd_addr[0] = 6'd5;
    #1 check_reads();
    tick();
    chk("wr5 data", 64'(rd_data[0]), 64'h12345678);
    chk("wr5 ready", 64'(rd_ready[0]), 64'd1);

    // Port conflict
    wr_en = 2'b11; wr_addr[0] = 6'd7; wr_addr[1] = 6'd7;
    wr_data[0] = 32'hAAAA0000; wr_data[1] = 32'hBBBB1111; rd_addr[1] = 6'd7;
    #1 check_reads();
    tick();
    chk("conflict data", 64'(rd_data[1]), 64'hBBBB1111);

    // Clear, write, then simultaneous write+clear on 9
    clr_en = 2'b01; clr_addr[0] = 6'd9; rd_addr[2] = 6'd9;
    tick();
    chk("clr9 ready", 64'(rd_ready[2]), 64'd0);
    wr_en = 2'b01; wr_addr[0] = 6'd9; wr_data[0] = 32'hDEADBEEF;
    tick();
    chk("wr9 data", 64'(rd_data[2]), 64'hDEADBEEF);
    chk("wr9 ready", 64'(rd_ready[2]), 64'd1);
    wr_en = 2'b10; wr_addr[1] = 6'd9; wr_data[1] = 32'h11112222;
    clr_en = 2'b10; clr_addr[1] = 6'd9;
    #1 check_reads();
    tick();
    chk("wr+clr9 data", 64'(rd_data[2]), 64'h11112222);
    chk("wr+clr9 ready", 64'(rd_ready[2]), 64'd0);

    // Zero register
    wr_en = 2'b01; wr_addr[0] = 6'd0; wr_data[0] = 32'hFFFFFFFF;
    clr_en = 2'b01; clr_addr[0] = 6'd0; rd_addr[3] = 6'd0;
    #1 check_reads();
    tick();
    chk("zero data", 64'(rd_data[3]), 64'd0);
    chk("zero ready", 64'(rd_ready[3]), 64'd1);
    chk("zero cur data", 64'(current_entry_reg_state[0]), 64'd0);
    check_state();

    // Init wins over write; entry 0 forced
    for (int e = 0; e < NE; e++) init_entry_reg_state[e] = $urandom;
    init_ready_state = {$urandom, $urandom};
    init_entry_reg_state[0] = 32'h5A5A5A5A; init_ready_state[0] = 1'b0;
    init_entry_reg_state[3] = 32'h0000CAFE; init_ready_state[3] = 1'b0;
    init = 1; wr_en = 2'b01; wr_addr[0] = 6'd3; wr_data[0] = 32'h77777777; rd_addr[0] = 6'd3;
    #1 check_reads();
    tick();
    chk("init e3 data", 64'(current_entry_reg_state[3]), 64'h0000CAFE);
    chk("init e3 ready", 64'(current_ready_state[3]), 64'd0);
    chk("init e0 data", 64'(current_entry_reg_state[0]), 64'd0);
    chk("init e0 ready", 64'(current_ready_state[0]), 64'd1);
    check_state();

    // Reset beats init and a pending write
    rst = 1; init = 1; wr_en = 2'b01; wr_addr[0] = 6'd4; wr_data[0] = 32'h44444444;
    #1 check_reads();
    tick();
    chk("rst+init e3 data", 64'(current_entry_reg_state[3]), 64'd0);
    chk("rst+init ready", 64'(current_ready_state), {64{1'b1}});
    check_state();

    // Randomized traffic on a narrow address window to force collisions
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NR; i++)
        rd_addr[i] = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, NE - 1)) : PW'($urandom_range(0, 7));
      for (int p = 0; p < NW; p++) begin
        wr_en[p] = 1'($urandom_range(0, 1)); wr_addr[p] = PW'($urandom_range(0, 7)); wr_data[p] = $urandom;
      end
      for (int c = 0; c < NC; c++) begin
        clr_en[c] = ($urandom_range(0, 2) == 0); clr_addr[c] = PW'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 19) == 0) begin
        init = 1;
        for (int e = 0; e < NE; e++) init_entry_reg_state[e] = $urandom;
        init_ready_state = {$urandom, $urandom};
      end
      rst = ($urandom_range(0, 29) == 0);
      #1 check_reads();
      tick();
      check_state();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/phys_regfile.md
# phys_regfile

Parametrised multi-ported physical register file for the out-of-order core, generalising the architectural regfile to N read, N write and N ready-clear ports. Each entry carries data plus a ready bit: rename clears it, writeback sets it, and issue logic reads both. Entry 0 is the hardwired zero register. Test/init ports load and expose the full state for directed benches.

## Interface
- N_ENTRIES, 64, number of physical registers (power of two, ≥2)
- ENTRY_WIDTH, 32, data bits per entry
- N_READ_PORTS, 4, read ports
- N_WRITE_PORTS, 2, writeback ports
- N_CLR_PORTS, 2, rename allocation (ready-clear) ports
- PTR_WIDTH, $clog2(N_ENTRIES), localparam

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  [N_READ_PORTS-1:0][PTR_WIDTH-1:0]  read addresses
- rd_data  out  [N_READ_PORTS-1:0][ENTRY_WIDTH-1:0]  read data
- rd_ready  out  [N_READ_PORTS-1:0]  ready bit of addressed entry
- wr_en  in  [N_WRITE_PORTS-1:0]  write enables
- wr_addr  in  [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]  write addresses
- wr_data  in  [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0]  write data
- clr_en  in  [N_CLR_PORTS-1:0]  ready-clear enables
- clr_addr  in  [N_CLR_PORTS-1:0][PTR_WIDTH-1:0]  entries to mark not-ready
- init  in  1  load init state next edge
- init_entry_reg_state  in  [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]  data to load
- init_ready_state  in  [N_ENTRIES-1:0]  ready bits to load
- current_entry_reg_state  out  [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]  live data state
- current_ready_state  out  [N_ENTRIES-1:0]  live ready state

## Operation
- Reset: all entries 0, all ready bits 1; rd_data 0, rd_ready 1 for every port while rst is held.
- Priority per edge: rst > init > normal update.
- init: entries and ready bits take init_* values; wr_en/clr_en ignored that cycle. Entry 0 forced to data 0, ready 1 regardless of init values.
- Write: wr_en[p] sets entry[wr_addr[p]] = wr_data[p] and ready = 1.
- Multiple write ports, same address: highest-indexed port wins.
- Clear: clr_en[c] sets ready[clr_addr[c]] = 0; data unchanged.
- Write and clear same entry same cycle: data written, ready ends 0 (clear wins).
- Address 0: writes and clears ignored; reads always return data 0, ready 1.
- Reads are combinational from current state (plus bypass, see Configuration). Reads never modify state.
- current_* outputs reflect registered state only (no bypass).

## Timing
- Read latency: combinational, same cycle.
- Write/clear/init visible in state one edge after assertion.
- Without bypass: read of address written in cycle t returns new value in cycle t+1.
- Reset mid-operation: pending write/clear in the reset cycle is discarded; state is reset values after the edge.

## Configuration
- PHYS_REGFILE_BYPASS_EN defined: rd_data/rd_ready forward same-cycle writes — if any wr_en[p] targets rd_addr (≠0), rd_data = winning wr_data, rd_ready = 1 unless a same-cycle clr_en targets that address (then 0). Bypass suppressed while rst or init is high.
- Undefined: reads return registered state only; no write-to-read path.

## Test plan
- Reset: assert rst 1 cycle, rd_addr = {0,1,5,63} -> rd_data all 0, rd_ready all 1; current_ready_state all ones.
- Write then read: wr_en[0]=1, wr_addr=5, wr_data=32'h12345678; rd_addr[0]=5 -> same cycle 0 (bypass off) / 12345678 (bypass on); next cycle 12345678, ready 1.
- Port conflict: wr_en=2'b11, both addr 7, data 32'hAAAA0000 / 32'hBBBB1111 -> entry 7 = BBBB1111.
- Clear then write: clr_en[0]=1, clr_addr=9 -> rd_ready 0 next cycle; later wr_addr=9, data 32'hDEADBEEF -> ready 1, data DEADBEEF; simultaneous write+clear on 9 -> data written, ready 0.
- Zero register: wr_addr=0, data 32'hFFFFFFFF and clr_addr=0 -> rd_data 0, rd_ready 1 next cycle.
- Init/reset precedence: init with entry 3 = 32'h0000CAFE, ready[3]=0, plus wr_en to 3 -> entry 3 = 0000CAFE, ready 0; rst and init together -> reset values.
